// File: rtl/pa_muldiv_pkg.sv
// Shared encodings for the P-A multiply/divide engine: op codes and FSM states.
package pa_pkg;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVS = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/pa_muldiv_if.sv
// Microcontrol-side bus of the multiply/divide engine; vectors are bit 0 = MSB.
interface pa_muldiv_if
  import pa_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  // Handshake: start is sampled only while the engine is IDLE (operands are
  // captured on that same edge); busy is high from the following edge until
  // done; done is a single-cycle pulse during which results are valid, and
  // hi/lo/z/m/v then hold until the next accepted start.
  logic             start;
  logic [0:1]       op;
  logic [0:WIDTH-1] a;
  logic [0:WIDTH-1] b;
  logic [0:WIDTH-1] dh;
  logic             busy;
  logic             done;
  logic [0:WIDTH-1] hi;
  logic [0:WIDTH-1] lo;
  logic             z;
  logic             m;
  logic             v;
  state_t           dbg_state;

  modport master (
    output start, op, a, b, dh,
    input  busy, done, hi, lo, z, m, v, dbg_state
  );

  modport slave (
    input  start, op, a, b, dh,
    output busy, done, hi, lo, z, m, v, dbg_state
  );

endinterface

// File: rtl/pa_md_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module pa_md_step #(
  parameter int WIDTH = 16
) (
  input  logic             is_div_i,
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] sh_i,
  input  logic [WIDTH-1:0] mc_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] sh_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i[WIDTH-1:0]} + (sh_i[0] ? {1'b0, mc_i} : '0);
    shifted = {acc_i[WIDTH-1:0], sh_i[WIDTH-1]};
    diff    = shifted - {1'b0, mc_i};
    acc_o   = '0;
    sh_o    = '0;
    if (is_div_i) begin
      // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
      if (shifted >= {1'b0, mc_i}) begin
        acc_o = diff;
        sh_o  = {sh_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted;
        sh_o  = {sh_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {1'b0, sum[WIDTH:1]};
      sh_o  = {sum[0], sh_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/pa_muldiv.sv
// Iterative multiply/divide engine with sign fix-up and overflow detection.
// Optional macro PA_MULDIV_EARLY_OUT_EN: MUL with a zero operand skips the iterations.
module pa_muldiv
  import pa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic        clk_sys,
  input logic        clear,
  pa_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] Q_POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, dh_q, dh_d, mc_q, mc_d, sh_q, sh_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prep_q, prep_d, sa_q, sa_d, sb_q, sb_d, ovf_q, ovf_d;
  logic             z_q, z_d, m_q, m_d, v_q, v_d;

  logic             is_div, is_signed, a_neg, b_neg, dvd_neg;
  logic [WIDTH-1:0] a_mag, b_mag, qmag, quo, rem;
  logic [2*WIDTH-1:0] dvd_raw, dvd_mag, prod_mag, prod;
  logic             early_out, short_path, div_ovf;
  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_sh;

  assign is_div    = op_q[1];
  assign is_signed = (op_q == OP_MULS) || (op_q == OP_DIVS);
  assign a_neg     = is_signed && a_q[WIDTH-1];
  assign b_neg     = (op_q == OP_MULS) && b_q[WIDTH-1];
  assign dvd_neg   = (op_q == OP_DIVS) && dh_q[WIDTH-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;
  assign dvd_raw   = {dh_q, b_q};
  assign dvd_mag   = dvd_neg ? -dvd_raw : dvd_raw;

`ifdef PA_MULDIV_EARLY_OUT_EN
  assign early_out = !is_div && ((a_q == '0) || (b_q == '0));
`else
  assign early_out = 1'b0;
`endif
  assign short_path = early_out || (is_div && (a_q == '0)) ||
                      ((op_q == OP_DIVU) && (dh_q >= a_q));

  // Fix-up: sign correction of product, quotient and remainder magnitudes.
  assign prod_mag = {acc_q[WIDTH-1:0], sh_q};
  assign prod     = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
  assign qmag     = sh_q;
  assign quo      = (sa_q ^ sb_q) ? -qmag : qmag;
  assign rem      = sb_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign div_ovf  = ovf_q || ((op_q == OP_DIVS) &&
                    ((sa_q ^ sb_q) ? (qmag > Q_NEG_MAX) : (qmag > Q_POS_MAX)));

  pa_md_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .sh_i     (sh_q),
    .mc_i     (mc_q),
    .acc_o    (step_acc),
    .sh_o     (step_sh)
  );

  always_ff @(posedge clk_sys) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (prep_q) state_d = short_path ? DONE : ITER;
      ITER:    if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q == LOAD) || (state_q == ITER) || (state_q == FIX);
    bus.done      = (state_q == DONE);
    bus.hi        = hi_q;
    bus.lo        = lo_q;
    bus.z         = z_q;
    bus.m         = m_q;
    bus.v         = v_q;
    bus.dbg_state = state_q;
  end

  // LOAD spends one cycle forming magnitudes, then one cycle on the prechecks.
  always_comb begin
    op_d = op_q;  a_d = a_q;   b_d = b_q;   dh_d = dh_q;  mc_d = mc_q;
    sh_d = sh_q;  acc_d = acc_q; cnt_d = cnt_q; prep_d = prep_q;
    sa_d = sa_q;  sb_d = sb_q; ovf_d = ovf_q;
    hi_d = hi_q;  lo_d = lo_q; z_d = z_q; m_d = m_q; v_d = v_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        op_d = bus.op;  a_d = bus.a;  b_d = bus.b;  dh_d = bus.dh;
        prep_d = 1'b0;
      end
      LOAD: if (!prep_q) begin
        prep_d = 1'b1;
        cnt_d  = CNT_W'(WIDTH);
        sa_d   = a_neg;
        sb_d   = b_neg | dvd_neg;
        mc_d   = a_mag;
        acc_d  = is_div ? {1'b0, dvd_mag[2*WIDTH-1:WIDTH]} : '0;
        sh_d   = is_div ? dvd_mag[WIDTH-1:0] : b_mag;
      end else begin
        ovf_d = (op_q == OP_DIVS) && (acc_q[WIDTH-1:0] >= mc_q);
        if (early_out) begin
          hi_d = '0;  lo_d = '0;  z_d = 1'b1;  m_d = 1'b0;  v_d = 1'b0;
        end else if (short_path) begin
          hi_d = dh_q;  lo_d = b_q;  z_d = (b_q == '0);  m_d = b_q[WIDTH-1];  v_d = 1'b1;
        end
      end
      ITER: begin
        acc_d = step_acc;
        sh_d  = step_sh;
        cnt_d = cnt_q - 1'b1;
      end
      FIX: begin
        if (!is_div) begin
          hi_d = prod[2*WIDTH-1:WIDTH];  lo_d = prod[WIDTH-1:0];
          z_d  = (prod == '0);  m_d = prod[2*WIDTH-1];  v_d = 1'b0;
        end else if (div_ovf) begin
          hi_d = dh_q;  lo_d = b_q;  z_d = (b_q == '0);  m_d = b_q[WIDTH-1];  v_d = 1'b1;
        end else begin
          hi_d = rem;  lo_d = quo;  z_d = (quo == '0);  m_d = quo[WIDTH-1];  v_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (clear) begin
      op_q <= '0;  a_q <= '0;  b_q <= '0;  dh_q <= '0;  mc_q <= '0;
      sh_q <= '0;  acc_q <= '0; cnt_q <= '0; prep_q <= 1'b0;
      sa_q <= 1'b0; sb_q <= 1'b0; ovf_q <= 1'b0;
      hi_q <= '0;  lo_q <= '0;  z_q <= 1'b0; m_q <= 1'b0; v_q <= 1'b0;
    end else begin
      op_q <= op_d;  a_q <= a_d;  b_q <= b_d;  dh_q <= dh_d;  mc_q <= mc_d;
      sh_q <= sh_d;  acc_q <= acc_d; cnt_q <= cnt_d; prep_q <= prep_d;
      sa_q <= sa_d;  sb_q <= sb_d; ovf_q <= ovf_d;
      hi_q <= hi_d;  lo_q <= lo_d;  z_q <= z_d;  m_q <= m_d;  v_q <= v_d;
    end
  end

endmodule
